// File: rtl/uart_pkg.sv
`default_nettype none
// =====================================================================
// uart_pkg: shared receiver state encoding and bit-timing helpers.
// Rev 1.0
// =====================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Count value at which the start bit is re-checked, half a bit in.
  function automatic int mid_count(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// =====================================================================
// sync_fifo: single-clock FIFO with registered storage and head output.
// Rev 1.0
// =====================================================================
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_full_count);
  assign head  = r_mem[r_rd_ptr];

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_stream.sv
`default_nettype none
// =====================================================================
// uart_rx_stream: UART byte receiver feeding a valid/ready byte stream.
// Build option UART_RX_PARITY_EN selects 8E1 framing (default 8N1). Rev 1.0
// =====================================================================
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tvalid,
  output logic [DATA_BITS-1:0] tdata,
  input  logic                 tready,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_cnt_mid  = CNT_W'(mid_count(CLKS_PER_BIT));
  localparam logic [2:0]       c_idx_last = 3'(DATA_BITS - 1);

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overflow;
  logic                 w_bit_end;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
`endif

  assign w_bit_end = (r_cnt == c_cnt_last);
  assign w_pop     = tvalid && tready;
`ifdef UART_RX_PARITY_EN
  assign w_push    = (r_state == STOP) && w_bit_end && r_rx_s && !r_par_bad;
`else
  assign w_push    = (r_state == STOP) && w_bit_end && r_rx_s;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overflow  <= w_push && w_full && !w_pop;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == c_cnt_mid) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_idx   <= r_idx + 1'b1;
            if (r_idx == c_idx_last) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= STOP;
            if (r_rx_s != ^r_shift) begin
              r_frame_err <= 1'b1;
              r_par_bad   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // A held-low line is a break, not a stream of framing errors.
        BREAK: begin
          r_cnt <= '0;
          if (r_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .din   (r_shift),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (tdata)
  );

  assign tvalid    = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stream.sv
`default_nettype none
// =====================================================================
// tb_uart_rx_stream: scoreboard bench for the UART byte receiver.
// Honours UART_RX_PARITY_EN (8E1 frames plus parity scenarios). Rev 1.0
// =====================================================================
module tb_uart_rx_stream;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic       tvalid;
  logic [7:0] tdata;
  logic       frame_err;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int tv_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_stream #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tvalid    (tvalid),
    .tdata     (tdata),
    .tready    (tready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // One clock: observe on the falling edge, return just after the rising edge.
  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    if (frame_err === 1'b1) fe_cnt++;
    if (overflow === 1'b1) ov_cnt++;
    if (tvalid === 1'b1) tv_cnt++;
    if (tvalid === 1'b1 && tready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: got %02h, none expected", tdata);
      end else begin
        e = exp_q.pop_front();
        if (tdata !== e) begin
          n_err++;
          $display("FAIL byte_order: got %02h, expected %02h", tdata, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bits(input int n);
    repeat (n * CPB) cyc();
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input bit expect_ok);
    if (expect_ok) exp_q.push_back(d);
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^d;
    bits(1);
`endif
    rx = stop;
    bits(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    n_vec++;
    if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b, expected 0", tvalid); end
    n_vec++;
    if (tdata !== 8'h00) begin n_err++; $display("FAIL reset_tdata: got %02h, expected 00", tdata); end
    n_vec++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    reset = 1'b1;
    bits(2);
  endtask

  task automatic test_single();
    int fe0 = fe_cnt;
    int tv0 = tv_cnt;
    send(8'h77, 1'b1, 1'b1);
    bits(2);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
    n_vec++;
    if (tv_cnt - tv0 != 1) begin n_err++; $display("FAIL single_tvalid_cycles: got %0d, expected 1", tv_cnt - tv0); end
    n_vec++;
    if (fe_cnt != fe0) begin n_err++; $display("FAIL single_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    string s = "write 1f deadbeef\n";
    int fe0 = fe_cnt;
    int ov0 = ov_cnt;
    int tv0 = tv_cnt;
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1, 1'b1);
    bits(2);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: %0d bytes outstanding, expected 0", exp_q.size()); end
    n_vec++;
    if (tv_cnt - tv0 != 18) begin n_err++; $display("FAIL b2b_count: got %0d bytes, expected 18", tv_cnt - tv0); end
    n_vec++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      n_err++;
      $display("FAIL b2b_errors: got fe=%0d ov=%0d, expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_backpressure();
    int ov0 = ov_cnt;
    tready = 1'b0;
    for (int b = 8'h31; b <= 8'h34; b++) send(8'(b), 1'b1, 1'b1);
    bits(1);
    n_vec++;
    if (tvalid !== 1'b1 || tdata !== 8'h31) begin
      n_err++;
      $display("FAIL bp_head_full: got tvalid=%b tdata=%02h, expected 1 31", tvalid, tdata);
    end
    n_vec++;
    if (ov_cnt != ov0) begin n_err++; $display("FAIL bp_early_overflow: got %0d pulses, expected 0", ov_cnt - ov0); end
    send(8'h35, 1'b1, 1'b0);
    bits(1);
    n_vec++;
    if (ov_cnt - ov0 != 1) begin n_err++; $display("FAIL bp_overflow: got %0d pulses, expected 1", ov_cnt - ov0); end
    n_vec++;
    if (tdata !== 8'h31) begin n_err++; $display("FAIL bp_head_stable: got %02h, expected 31", tdata); end
    tready = 1'b1;
    bits(1);
    n_vec++;
    if (exp_q.size() != 0 || tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: outstanding=%0d tvalid=%b, expected 0 0", exp_q.size(), tvalid);
    end
  endtask

  task automatic test_framing_break();
    int fe0 = fe_cnt;
    int tv0 = tv_cnt;
    send(8'h41, 1'b0, 1'b0);
    bits(30);
    rx = 1'b1;
    bits(2);
    send(8'h42, 1'b1, 1'b1);
    bits(2);
    n_vec++;
    if (fe_cnt - fe0 != 1) begin n_err++; $display("FAIL break_frame_err: got %0d pulses, expected 1", fe_cnt - fe0); end
    n_vec++;
    if (tv_cnt - tv0 != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL break_delivery: got %0d bytes, outstanding=%0d, expected 1 0", tv_cnt - tv0, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int fe0 = fe_cnt;
    int tv0 = tv_cnt;
    rx = 1'b0;
    repeat (3) cyc();
    rx = 1'b1;
    bits(12);
    n_vec++;
    if (fe_cnt != fe0 || tv_cnt != tv0) begin
      n_err++;
      $display("FAIL glitch: got fe=%0d bytes=%0d, expected 0 0", fe_cnt - fe0, tv_cnt - tv0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d = 8'h55;
    int fe0;
    int tv0;
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      bits(1);
    end
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) cyc();
    n_vec++;
    if ({tvalid, tdata, frame_err, overflow} !== 11'h0) begin
      n_err++;
      $display("FAIL midframe_reset: got tvalid=%b tdata=%02h fe=%b ov=%b, expected all 0",
               tvalid, tdata, frame_err, overflow);
    end
    reset = 1'b1;
    bits(2);
    fe0 = fe_cnt;
    tv0 = tv_cnt;
    send(8'h56, 1'b1, 1'b1);
    bits(2);
    n_vec++;
    if (tv_cnt - tv0 != 1 || exp_q.size() != 0 || fe_cnt != fe0) begin
      n_err++;
      $display("FAIL after_reset_rx: got bytes=%0d outstanding=%0d fe=%0d, expected 1 0 0",
               tv_cnt - tv0, exp_q.size(), fe_cnt - fe0);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d = 8'h03;
    for (int p = 0; p < 2; p++) begin
      int fe0 = fe_cnt;
      int tv0 = tv_cnt;
      if (p == 0) exp_q.push_back(d);
      rx = 1'b0;
      bits(1);
      for (int i = 0; i < 8; i++) begin
        rx = d[i];
        bits(1);
      end
      rx = 1'(p);
      bits(1);
      rx = 1'b1;
      bits(3);
      n_vec++;
      if (fe_cnt - fe0 != p) begin n_err++; $display("FAIL parity_err_p%0d: got %0d pulses, expected %0d", p, fe_cnt - fe0, p); end
      n_vec++;
      if (tv_cnt - tv0 != 1 - p || exp_q.size() != 0) begin
        n_err++;
        $display("FAIL parity_delivery_p%0d: got %0d bytes, expected %0d", p, tv_cnt - tv0, 1 - p);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_framing_break();
    test_glitch();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
Upstream stage of the ASCII command path: receives 8N1 serial bytes on a UART line and presents them as an 8-bit AXI-Stream-style byte stream (tvalid/tdata/tready) to the command decoder. It includes an input synchroniser, a bit-timing state machine with midpoint sampling and framing checks, and a small output FIFO. The FIFO absorbs decoder back-pressure while the decoder drives its bus transaction.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
FIFO_DEPTH_LOG2, 2, log2 of output FIFO depth (default depth 4 bytes).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  reset, asynchronous assert, active-low (0 = reset).
rx  in  1  asynchronous serial input; idle high.
tvalid  out  1  byte available at FIFO head.
tdata  out  8  FIFO head byte.
tready  in  1  consumer accepts; pop when tvalid && tready.
frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity error, see option).
overflow  out  1  one-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset (reset=0, async): synchroniser flops=1, state=IDLE, counters=0, FIFO empty; tvalid=0, tdata=0, frame_err=0, overflow=0.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx 0..7.
- IDLE: rx_s==0 -> START, cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1 (midpoint), rx_s==0 -> DATA, cnt=0, idx=0; rx_s==1 -> IDLE (glitch, no error).
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift register LSB-first, cnt=0; after idx 7 -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1 -> push byte, go to IDLE.
  - 0 -> frame_err pulse, byte discarded, go to BREAK.
- BREAK: wait for rx_s==1, then IDLE. Handles line break; no further errors are flagged while low.
- Push rule: accepted if FIFO not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped, the overflow pulse fires, and FIFO contents are unchanged.
- Latency: tvalid rises the cycle after the stop-bit sample clock edge (FIFO registered). Total ~2 + 9.5*CLKS_PER_BIT cycles from rx falling edge.
- FIFO: tvalid = !empty; tdata = head, stable while tvalid && !tready. Pointers wrap modulo depth; count is 0..DEPTH. Simultaneous push+pop when empty is not permitted (tvalid=0, no pop).
- Reset mid-frame aborts the frame; no pulse is generated.
- The receiver never stalls on back-pressure; only the FIFO fills.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state follows DATA, sampled at the bit boundary. If rx_s differs from the XOR of the 8 data bits, the byte is dropped and frame_err pulses at the parity sample; the FSM then still passes through STOP/BREAK handling. The frame lengthens by one bit.
- Undefined: 8N1 as above; no PARITY state exists.

Decomposition:
- Package uart_pkg: rx_state_t enum (IDLE, START, DATA, PARITY, STOP, BREAK), DATA_BITS=8 constant, and a helper function for the midpoint count.
- Sub-module sync_fifo: parameterised width/depth-log2, push/pop/full/empty/head. It is instantiated once; it is reusable for a future TX path.

Test Plan:
- CLKS_PER_BIT=8, tready=1: send 0x77 ('w') 8N1 -> tvalid pulses one cycle with tdata=0x77; frame_err=0.
- Send "write 1f deadbeef\n" back-to-back, tready=1 -> 18 bytes appear in order, matching the ASCII codes; no errors.
- tready=0, send 5 bytes 0x31..0x35 with depth 4 -> first four are held (tdata=0x31 stable); overflow pulses once at the 5th stop bit. Raising tready then drains 0x31..0x34.
- Stop bit forced 0 on byte 0x41 -> frame_err single pulse, no tvalid. Holding rx low 30 bit-times, then sending 0x42 -> only 0x42 is delivered.
- rx low pulse of 3 cycles (below midpoint) -> FSM returns to IDLE, no output, no error. Assert reset during DATA of 0x55 -> all outputs 0; the next 0x56 is received correctly.
- With UART_RX_PARITY_EN: 0x03 with parity bit 0 is delivered; with parity bit 1, frame_err pulses and no byte is delivered.
